// File: rtl/bird_motion.sv
// bird_motion: per-frame vertical kinematics for the bird sprite.
// Applies gravity and flap impulses, clamps at the screen edges and raises a
// sticky boundary-hit flag back to the bird state controller.
// Optional build macro BIRD_CEIL_HIT_EN: when defined, touching the ceiling is
// lethal (sets oBoundHit); otherwise the ceiling is a soft clamp.
module bird_motion #(
  parameter int Y_W        = 10,
  parameter int V_W        = 6,
  parameter int Y_INIT     = 232,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 464,
  parameter int GRAVITY    = 1,
  parameter int FLAP_SPEED = 8,
  parameter int V_MAX      = 10,
  parameter int COOLDOWN   = 3
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iBirdPosRst,
  input  logic           iBirdMove,
  input  logic           iFrameTick,
  input  logic           iFlap,
  output logic [Y_W-1:0] oBirdY,
  output logic [V_W-1:0] oBirdVel,
  output logic           oFlapApplied,
  output logic           oBoundHit
);

  // Two guard bits let the position sum go negative or past the bottom
  // limit without wrapping before the clamp decision is made.
  localparam int SW   = Y_W + 2;
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [Y_W-1:0]         y_q, y_d;
  logic signed [V_W-1:0]  vel_q, vel_d;
  logic                   fa_q, fa_d;
  logic                   hit_q, hit_d;
  logic                   pend_q, pend_d;
  logic                   flap_r_q, flap_r_d;
  logic [CD_W-1:0]        cd_q, cd_d;

  logic                   flap_edge, edge_ok, tick, want, apply;
  logic signed [SW-1:0]   vel_g, vel_n, y_sum;

  // Next-state: flap capture, motion tick update, clamping, position reset.
  always_comb begin
    y_d      = y_q;
    vel_d    = vel_q;
    fa_d     = 1'b0;
    hit_d    = hit_q;
    cd_d     = cd_q;
    flap_r_d = iFlap;

    flap_edge = iFlap & ~flap_r_q;
    // Edges are only accepted with the cooldown expired and the bird alive.
    edge_ok   = flap_edge & (cd_q == '0) & ~hit_q;
    tick      = iFrameTick & iBirdMove & ~hit_q;
    want      = pend_q | edge_ok;
    // A flap pulse never repeats on back-to-back cycles; a blocked request
    // simply stays pending.
    apply     = tick & want & ~fa_q;
    pend_d    = want & ~hit_q;

    vel_g = SW'(vel_q) + SW'(GRAVITY);
    if (apply)
      vel_n = SW'(-FLAP_SPEED);
    else if (vel_g > SW'(V_MAX))
      vel_n = SW'(V_MAX);
    else
      vel_n = vel_g;
    y_sum = $signed({2'b00, y_q}) + vel_n;

    if (tick) begin
      if (apply) begin
        pend_d = 1'b0;
        cd_d   = CD_W'(COOLDOWN);
        fa_d   = 1'b1;
      end else if (cd_q != '0) begin
        cd_d = cd_q - CD_W'(1);
      end
      if (y_sum >= SW'(Y_MAX)) begin
        y_d   = Y_W'(Y_MAX);
        vel_d = '0;
        hit_d = 1'b1;
      end else if (y_sum < SW'(Y_MIN)) begin
        y_d   = Y_W'(Y_MIN);
        vel_d = '0;
`ifdef BIRD_CEIL_HIT_EN
        hit_d = 1'b1;
`else
        hit_d = hit_q;
`endif
      end else begin
        y_d   = y_sum[Y_W-1:0];
        vel_d = vel_n[V_W-1:0];
      end
    end

    // Position reset from the controller overrides any update this cycle.
    if (iBirdPosRst) begin
      y_d      = Y_W'(Y_INIT);
      vel_d    = '0;
      fa_d     = 1'b0;
      hit_d    = 1'b0;
      pend_d   = 1'b0;
      cd_d     = '0;
      flap_r_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      y_q      <= Y_W'(Y_INIT);
      vel_q    <= '0;
      fa_q     <= 1'b0;
      hit_q    <= 1'b0;
      pend_q   <= 1'b0;
      cd_q     <= '0;
      flap_r_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      vel_q    <= vel_d;
      fa_q     <= fa_d;
      hit_q    <= hit_d;
      pend_q   <= pend_d;
      cd_q     <= cd_d;
      flap_r_q <= flap_r_d;
    end
  end

  assign oBirdY       = y_q;
  assign oBirdVel     = vel_q;
  assign oFlapApplied = fa_q;
  assign oBoundHit    = hit_q;

endmodule

// File: tb/tb_bird_motion.sv
// Scoreboard bench for bird_motion: every frame tick pushes the expected
// post-tick state; a monitor pops and compares on the cycle after the tick.
module tb_bird_motion;

  logic       iClk = 1'b0;
  logic       iRst, iBirdPosRst, iBirdMove, iFrameTick, iFlap;
  logic [9:0] oBirdY;
  logic [5:0] oBirdVel;
  logic       oFlapApplied, oBoundHit;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int y;
    int v;
    bit fa;
    bit hit;
  } exp_t;

  exp_t q[$];
  logic tick_seen = 1'b0;
  logic fa_prev   = 1'b0;

`ifdef BIRD_CEIL_HIT_EN
  localparam bit CEIL_HIT = 1'b1;
`else
  localparam bit CEIL_HIT = 1'b0;
`endif

  bird_motion dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iBirdPosRst  (iBirdPosRst),
    .iBirdMove    (iBirdMove),
    .iFrameTick   (iFrameTick),
    .iFlap        (iFlap),
    .oBirdY       (oBirdY),
    .oBirdVel     (oBirdVel),
    .oFlapApplied (oFlapApplied),
    .oBoundHit    (oBoundHit)
  );

  always #5 iClk = ~iClk;

  // Remember which cycles carried a tick so the monitor knows when to compare.
  always @(posedge iClk) tick_seen <= iFrameTick;

  // Monitor: compare DUT state against the scoreboard after each tick.
  always @(negedge iClk) begin
    if (fa_prev) begin
      checks++;
      if (oFlapApplied) begin
        failures++;
        $display("FAIL flap_pulse_width: oFlapApplied high two cycles in a row");
      end
    end
    fa_prev = oFlapApplied;
    if (tick_seen) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: tick response with no expectation y=%0d", oBirdY);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(oBirdY) != e.y || int'($signed(oBirdVel)) != e.v ||
            oFlapApplied != e.fa || oBoundHit != e.hit) begin
          failures++;
          $display("FAIL tick_state: got y=%0d v=%0d fa=%0b hit=%0b expected y=%0d v=%0d fa=%0b hit=%0b",
                   oBirdY, $signed(oBirdVel), oFlapApplied, oBoundHit, e.y, e.v, e.fa, e.hit);
        end
      end
    end
  end

  task automatic push(input int y, input int v, input bit fa, input bit hit);
    exp_t e;
    e.y = y; e.v = v; e.fa = fa; e.hit = hit;
    q.push_back(e);
  endtask

  task automatic tick(input int y, input int v, input bit fa, input bit hit);
    push(y, v, fa, hit);
    @(posedge iClk); #1 iFrameTick = 1'b1;
    @(posedge iClk); #1 iFrameTick = 1'b0;
  endtask

  // Flap edge on the same cycle as the tick.
  task automatic tick_flap(input int y, input int v, input bit fa, input bit hit);
    push(y, v, fa, hit);
    @(posedge iClk); #1 iFrameTick = 1'b1; iFlap = 1'b1;
    @(posedge iClk); #1 iFrameTick = 1'b0; iFlap = 1'b0;
  endtask

  // Position reset coinciding with a tick.
  task automatic tick_posrst();
    push(232, 0, 1'b0, 1'b0);
    @(posedge iClk); #1 iFrameTick = 1'b1; iBirdPosRst = 1'b1;
    @(posedge iClk); #1 iFrameTick = 1'b0; iBirdPosRst = 1'b0;
  endtask

  task automatic flap();
    @(posedge iClk); #1 iFlap = 1'b1;
    @(posedge iClk); #1 iFlap = 1'b0;
  endtask

  task automatic chk_now(input string name, input int y, input int v, input bit fa, input bit hit);
    @(negedge iClk);
    checks++;
    if (int'(oBirdY) != y || int'($signed(oBirdVel)) != v ||
        oFlapApplied != fa || oBoundHit != hit) begin
      failures++;
      $display("FAIL %s: got y=%0d v=%0d fa=%0b hit=%0b expected y=%0d v=%0d fa=%0b hit=%0b",
               name, oBirdY, $signed(oBirdVel), oFlapApplied, oBoundHit, y, v, fa, hit);
    end
  endtask

  task automatic pos_rst();
    @(posedge iClk); #1 iBirdPosRst = 1'b1;
    @(posedge iClk); #1 iBirdPosRst = 1'b0;
    chk_now("pos_reset", 232, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int y, b;
    iRst = 1'b1; iBirdPosRst = 1'b0; iBirdMove = 1'b0; iFrameTick = 1'b0; iFlap = 1'b0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    chk_now("reset", 232, 0, 1'b0, 1'b0);

    // Free fall
    iBirdMove = 1'b1;
    tick(233, 1, 0, 0);
    tick(235, 2, 0, 0);
    tick(238, 3, 0, 0);

    // Flap, then a flap during cooldown which must be discarded
    flap();
    tick(230, -8, 1, 0);
    flap();
    tick(223, -7, 0, 0);
    tick(217, -6, 0, 0);
    tick(212, -5, 0, 0);
    flap();
    tick(204, -8, 1, 0);

    // Climb toward the ceiling: 3 falling ticks then a flap, repeated
    for (int g = 0; g < 7; g++) begin
      b = 204 - 26 * g;
      tick(b - 7, -7, 0, 0);
      tick(b - 13, -6, 0, 0);
      tick(b - 18, -5, 0, 0);
      if (g == 3) tick_flap(b - 26, -8, 1, 0);
      else begin
        flap();
        tick(b - 26, -8, 1, 0);
      end
    end
    tick(15, -7, 0, 0);
    tick(9, -6, 0, 0);
    tick(4, -5, 0, 0);
    flap();
    tick(0, 0, 1, CEIL_HIT);
    if (CEIL_HIT) tick(0, 0, 0, 1);
    else tick(1, 1, 0, 0);

    // Pause: motion frozen, flap latched and applied on first moving tick
    pos_rst();
    tick(233, 1, 0, 0);
    tick(235, 2, 0, 0);
    iBirdMove = 1'b0;
    repeat (5) tick(235, 2, 0, 0);
    flap();
    iBirdMove = 1'b1;
    tick(227, -8, 1, 0);

    // Position reset racing a tick
    tick_posrst();

    // Bottom boundary: land exactly on Y_MAX
    tick(233, 1, 0, 0);
    tick(235, 2, 0, 0);
    flap();
    tick(227, -8, 1, 0);
    y = 227;
    for (int v = -7; v <= 10; v++) begin
      y += v;
      tick(y, v, 0, 0);
    end
    for (int k = 0; k < 20; k++) begin
      y += 10;
      tick(y, 10, 0, 0);
    end
    tick(464, 0, 0, 1);
    tick_flap(464, 0, 0, 1);
    tick(464, 0, 0, 1);
    pos_rst();
    tick(233, 1, 0, 0);

    repeat (4) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
